cpu_bus_target: RTL

Memory-side responder for the 2A03 core's external bus. Decodes each CPU bus cycle against a base/mask window and forwards selected reads and writes to a slow backing store over a req/ack handshake. While the store is busy it stretches the CPU cycle by deasserting `O_ready`. Returned read data is held on `O_rd_data`, which gives open-bus behaviour for unselected addresses. It sits between the core's `O_addr`/`O_wr_data`/`O_rdwr`/`O_phy2`/`I_ready`/`I_rd_data` pins and a RAM or peripheral.

---
 rtl/cpu_bus_target_if.sv | 32 +++
 rtl/cpu_bus_target.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/cpu_bus_target_if.sv
// Bus bundle between the 2A03 core side and the memory-side responder.
// The slave modport is the responder; the master modport is the CPU and
// backing store together, which drive every I_* signal.
interface cpu_bus_target_if #(
    parameter int AW = 11
);
    logic [15:0]   I_addr;
    logic [7:0]    I_wr_data;
    logic          I_rdwr;
    logic          I_phy2;
    logic [7:0]    O_rd_data;
    logic          O_ready;
    logic          O_mem_req;
    logic          O_mem_we;
    logic [AW-1:0] O_mem_addr;
    logic [7:0]    O_mem_wdata;
    logic          I_mem_ack;
    logic [7:0]    I_mem_rdata;
    logic          O_timeout;

    modport slave (
        input  I_addr, I_wr_data, I_rdwr, I_phy2, I_mem_ack, I_mem_rdata,
        output O_rd_data, O_ready, O_mem_req, O_mem_we, O_mem_addr,
               O_mem_wdata, O_timeout
    );

    modport master (
        output I_addr, I_wr_data, I_rdwr, I_phy2, I_mem_ack, I_mem_rdata,
        input  O_rd_data, O_ready, O_mem_req, O_mem_we, O_mem_addr,
               O_mem_wdata, O_timeout
    );
endinterface

// File: rtl/cpu_bus_target.sv
// Memory-side responder for the 2A03 external bus. Decodes each phase-2
// cycle against a base/mask window, forwards selected accesses to a slow
// store over req/ack, stretches the CPU cycle through O_ready while the
// store is busy, and keeps an open-bus data latch on O_rd_data.
module cpu_bus_target #(
    parameter logic [15:0] BASE    = 16'h0000,
    parameter logic [15:0] MASK    = 16'hE000,
    parameter int          AW      = 11,
    parameter int          TIMEOUT = 15
) (
    input logic             I_clock,
    input logic             I_reset,
    cpu_bus_target_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [7:0] TO_CNT = 8'(TIMEOUT);

    state_t        state_q, state_d;
    logic          phy2_dly_q;
    logic          arm_q;
    logic [7:0]    cnt_q, cnt_d, cnt_inc;
    logic [7:0]    rd_data_q, rd_data_d;
    logic          timeout_q, timeout_d;
    logic          mem_req_q, mem_req_d;
    logic          mem_we_q, mem_we_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [7:0]    mem_wdata_q, mem_wdata_d;
    logic          cyc_sel_q, cyc_sel_d;
    logic          cyc_wr_q, cyc_wr_d;
    logic          rise, fall, selected;

    // arm_q blocks a phase-2 period that was already high when reset
    // released: it only sets once phy2 has been seen low.
    assign rise     = bus.I_phy2 & ~phy2_dly_q & arm_q;
    assign fall     = ~bus.I_phy2 & phy2_dly_q;
    assign selected = ((bus.I_addr & MASK) == BASE);
    assign cnt_inc  = cnt_q + 8'd1;

    // Phase-2 edge detector and post-reset arming.
    always_ff @(posedge I_clock) begin
        if (I_reset) begin
            phy2_dly_q <= 1'b0;
            arm_q      <= 1'b0;
        end else begin
            phy2_dly_q <= bus.I_phy2;
            if (!bus.I_phy2) begin
                arm_q <= 1'b1;
            end
        end
    end

    // Next-state, capture and data-latch decisions for one bus cycle.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rd_data_d   = rd_data_q;
        timeout_d   = timeout_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        cyc_sel_d   = cyc_sel_q;
        cyc_wr_d    = cyc_wr_q;

        unique case (state_q)
            S_IDLE: begin
                if (rise) begin
                    cyc_sel_d = selected;
                    cyc_wr_d  = ~bus.I_rdwr;
                    if (selected) begin
                        mem_addr_d  = bus.I_addr[AW-1:0];
                        mem_we_d    = ~bus.I_rdwr;
                        mem_wdata_d = bus.I_wr_data;
                        cnt_d       = 8'd0;
                        state_d     = S_REQ;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_REQ: begin
                cnt_d = cnt_inc;
                // Ack is checked first so a same-clock ack beats the timeout.
                if (bus.I_mem_ack) begin
                    rd_data_d = mem_we_q ? mem_wdata_q : bus.I_mem_rdata;
                    state_d   = S_DONE;
                end else if (cnt_inc == TO_CNT) begin
                    timeout_d = 1'b1;
                    state_d   = S_DONE;
                end
            end
            S_DONE: begin
                if (fall) begin
                    // An unselected write still drives the data bus, so the
                    // open-bus latch follows the CPU's write data.
                    if (!cyc_sel_q && cyc_wr_q) begin
                        rd_data_d = bus.I_wr_data;
                    end
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        mem_req_d = (state_d == S_REQ);
    end

    // State and registered outputs.
    always_ff @(posedge I_clock) begin
        if (I_reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= 8'd0;
            rd_data_q   <= 8'h00;
            timeout_q   <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= 8'h00;
            cyc_sel_q   <= 1'b0;
            cyc_wr_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rd_data_q   <= rd_data_d;
            timeout_q   <= timeout_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            cyc_sel_q   <= cyc_sel_d;
            cyc_wr_q    <= cyc_wr_d;
        end
    end

    assign bus.O_ready     = (state_q != S_REQ);
    assign bus.O_mem_req   = mem_req_q;
    assign bus.O_mem_we    = mem_we_q;
    assign bus.O_mem_addr  = mem_addr_q;
    assign bus.O_mem_wdata = mem_wdata_q;
    assign bus.O_rd_data   = rd_data_q;
    assign bus.O_timeout   = timeout_q;

endmodule
